// File: rtl/sw_poll_ctrl.sv
// rtl/sw_poll_ctrl.sv - periodic PIO switch poller with debounce and valid/ready hand-off
module sw_poll_ctrl #(
  parameter int WIDTH        = 10,
  parameter int POLL_CYCLES  = 50000,
  parameter int STABLE_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [1:0]       pio_address,
  output logic             pio_read,
  input  logic [31:0]      pio_readdata,
  output logic [WIDTH-1:0] sw_value,
  output logic             sw_valid,
  input  logic             sw_ready,
  output logic [WIDTH-1:0] sw_stable
);

  localparam int TW = $clog2(POLL_CYCLES);
  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam logic [TW-1:0] RELOAD = TW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] SAT    = CW'(STABLE_COUNT);

  typedef enum logic [1:0] {IDLE, READ, CAPTURE} state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    timer;
  logic             poll_req;
  logic [WIDTH-1:0] sample, last_sample, last_nxt, stable_nxt, committed;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             have_stable, have_stable_nxt, have_committed, offer;
  logic             unused_hi;

  assign pio_address = 2'b00;
  assign sample      = pio_readdata[WIDTH-1:0];
  assign unused_hi   = ^pio_readdata[31:WIDTH];
  assign poll_req    = enable && (timer == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       timer <= RELOAD;
    else if (!enable || timer == '0)    timer <= RELOAD;
    else                                timer <= timer - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // A started read always runs to CAPTURE, even if enable drops meanwhile.
  always_comb begin
    state_nxt = state;
    pio_read  = 1'b0;
    case (state)
      IDLE:    if (poll_req) state_nxt = READ;
      READ:    begin pio_read = 1'b1; state_nxt = CAPTURE; end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt         = cnt;
    last_nxt        = last_sample;
    stable_nxt      = sw_stable;
    have_stable_nxt = have_stable;
    if (state == CAPTURE) begin
      last_nxt = sample;
      if (sample == last_sample) cnt_nxt = (cnt == SAT) ? SAT : cnt + 1'b1;
      else                       cnt_nxt = CW'(1);
      if (cnt_nxt == SAT) begin
        stable_nxt      = sample;
        have_stable_nxt = 1'b1;
      end
    end
  end

  // Offer looks at the value being written to sw_stable so the report
  // leaves on the same edge that publishes the new stable word.
  assign offer = !sw_valid && have_stable_nxt &&
                 (!have_committed || (stable_nxt != committed));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      last_sample <= '0;
      sw_stable   <= '0;
      have_stable <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      last_sample <= last_nxt;
      sw_stable   <= stable_nxt;
      have_stable <= have_stable_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_value       <= '0;
      sw_valid       <= 1'b0;
      committed      <= '0;
      have_committed <= 1'b0;
    end else if (sw_valid && sw_ready) begin
      committed      <= sw_value;
      have_committed <= 1'b1;
      sw_valid       <= 1'b0;
    end else if (offer) begin
      sw_value <= stable_nxt;
      sw_valid <= 1'b1;
    end
  end

endmodule
